// File: rtl/toggle_chk_pkg.sv
// Shared definitions for the toggle pattern checker: FSM state encoding,
// LOCK_COUNT bounds and the width of the internal acquire counter.
package toggle_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_FAULT   = 2'd3
    } state_e;

    // Legal range of the LOCK_COUNT parameter.
    localparam int LOCK_COUNT_MIN = 1;
    localparam int LOCK_COUNT_MAX = 15;

    // Acquire counter only ever needs to reach LOCK_COUNT_MAX-1.
    localparam int GOOD_W = 4;

endpackage

// File: rtl/toggle_pattern_checker_negedge_capture.sv
// Half-cycle retiming flop: samples the upstream toggle on the falling
// edge so it is stable mid-cycle, well away from the source's rising edge.
module negedge_capture (
    input  logic CLK,
    input  logic RST,
    input  logic d_i,
    output logic q_o
);

    // Falling-edge capture with asynchronous active-high reset.
    always_ff @(negedge CLK or posedge RST) begin
        if (RST) begin
            q_o <= 1'b0;
        end else begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/toggle_pattern_checker.sv
// Toggle pattern checker: verifies that tog_in inverts on every rising CLK
// edge. After LOCK_COUNT consecutive good toggles it locks, then counts good
// toggles (wrapping) and misses (saturating). A miss while locked enters FAULT.
//
// Build option TOGGLE_CHK_STICKY_FAULT_EN:
//   defined   - FAULT persists until RST or en=0; misses in FAULT not counted.
//   undefined - FAULT lasts one cycle, then the checker re-acquires.
//
// The FSM state is exposed directly on the 'state' output for observation.
module toggle_pattern_checker #(
    parameter int LOCK_COUNT = 4,
    parameter int CNT_W      = 16,
    parameter int ERR_W      = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             en,
    input  logic             tog_in,
    output logic [1:0]       state,
    output logic             locked,
    output logic             fault,
    output logic [CNT_W-1:0] tog_cnt,
    output logic [ERR_W-1:0] err_cnt
);
    import toggle_chk_pkg::*;

    // Acquire count value at which the next good toggle completes the lock.
    localparam logic [GOOD_W-1:0] LOCK_LAST = GOOD_W'(LOCK_COUNT - 1);

    logic              neg_q;
    logic              neg_prev_q;
    logic              ok;

    state_e            state_q, state_d;
    logic [GOOD_W-1:0] good_cnt_q, good_cnt_d;
    logic [CNT_W-1:0]  tog_cnt_q, tog_cnt_d;
    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
    logic              locked_q, fault_q;

    negedge_capture u_neg_cap (
        .CLK (CLK),
        .RST (RST),
        .d_i (tog_in),
        .q_o (neg_q)
    );

    // Remember the previous half-cycle sample to detect an inversion.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            neg_prev_q <= 1'b0;
        end else begin
            neg_prev_q <= neg_q;
        end
    end

    // A good toggle is a change between consecutive retimed samples.
    assign ok = (neg_q != neg_prev_q);

    // Next-state and counter update logic.
    always_comb begin
        state_d    = state_q;
        good_cnt_d = good_cnt_q;
        tog_cnt_d  = tog_cnt_q;
        err_cnt_d  = err_cnt_q;

        if (!en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // The sample on the enabling edge is not trusted.
                    state_d    = ST_ACQUIRE;
                    good_cnt_d = '0;
                end
                ST_ACQUIRE: begin
                    if (ok) begin
                        good_cnt_d = good_cnt_q + GOOD_W'(1);
                        if (good_cnt_q == LOCK_LAST) begin
                            state_d = ST_LOCKED;
                        end
                    end else begin
                        good_cnt_d = '0;
                    end
                end
                ST_LOCKED: begin
                    if (ok) begin
                        tog_cnt_d = tog_cnt_q + CNT_W'(1);
                    end else begin
                        if (err_cnt_q != {ERR_W{1'b1}}) begin
                            err_cnt_d = err_cnt_q + ERR_W'(1);
                        end
                        state_d = ST_FAULT;
                    end
                end
                ST_FAULT: begin
`ifdef TOGGLE_CHK_STICKY_FAULT_EN
                    // Hold FAULT; only en=0 or RST leaves it.
                    state_d = ST_FAULT;
`else
                    state_d    = ST_ACQUIRE;
                    good_cnt_d = '0;
`endif
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State, counters and registered state decodes.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            good_cnt_q <= '0;
            tog_cnt_q  <= '0;
            err_cnt_q  <= '0;
            locked_q   <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            good_cnt_q <= good_cnt_d;
            tog_cnt_q  <= tog_cnt_d;
            err_cnt_q  <= err_cnt_d;
            locked_q   <= (state_d == ST_LOCKED);
            fault_q    <= (state_d == ST_FAULT);
        end
    end

    assign state   = state_q;
    assign locked  = locked_q;
    assign fault   = fault_q;
    assign tog_cnt = tog_cnt_q;
    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_toggle_pattern_checker.sv
// Testbench for toggle_pattern_checker (small counters so wrap and
// saturation are reachable). Honours TOGGLE_CHK_STICKY_FAULT_EN.
module tb_toggle_pattern_checker;

    localparam int LOCK_COUNT = 4;
    localparam int CNT_W      = 4;
    localparam int ERR_W      = 2;
    localparam int OUT_W      = 4 + CNT_W + ERR_W;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACQ  = 2'd1;
    localparam logic [1:0] S_LOCK = 2'd2;
    localparam logic [1:0] S_FLT  = 2'd3;

    logic             CLK;
    logic             RST;
    logic             en;
    logic             tog_in;
    logic [1:0]       state;
    logic             locked;
    logic             fault;
    logic [CNT_W-1:0] tog_cnt;
    logic [ERR_W-1:0] err_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [OUT_W-1:0] exp_q[$];

    // Reference model of the checker, advanced once per rising edge.
    logic [1:0]       m_state;
    logic [3:0]       m_good;
    logic [CNT_W-1:0] m_tog;
    logic [ERR_W-1:0] m_err;
    logic             m_prev;

    typedef struct {
        logic       en;
        logic       tog;
        logic [1:0] exp_state;
    } vec_t;

    vec_t tbl[9];

    toggle_pattern_checker #(
        .LOCK_COUNT (LOCK_COUNT),
        .CNT_W      (CNT_W),
        .ERR_W      (ERR_W)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .en      (en),
        .tog_in  (tog_in),
        .state   (state),
        .locked  (locked),
        .fault   (fault),
        .tog_cnt (tog_cnt),
        .err_cnt (err_cnt)
    );

    // Clock: 10 ns period, rising edges at 5, 15, 25, ...
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_state = S_IDLE;
        m_good  = '0;
        m_tog   = '0;
        m_err   = '0;
        m_prev  = 1'b0;
    endtask

    // One rising edge of the expected behaviour; tog_v is the value the
    // source held during the cycle just ending.
    task automatic model_edge(input logic en_v, input logic tog_v);
        logic ok;
        ok     = (tog_v != m_prev);
        m_prev = tog_v;
        if (!en_v) begin
            m_state = S_IDLE;
        end else begin
            case (m_state)
                S_IDLE: begin
                    m_state = S_ACQ;
                    m_good  = '0;
                end
                S_ACQ: begin
                    if (!ok) m_good = '0;
                    else if (m_good == 4'(LOCK_COUNT - 1)) m_state = S_LOCK;
                    else m_good = m_good + 4'd1;
                end
                S_LOCK: begin
                    if (ok) m_tog = m_tog + 1'b1;
                    else begin
                        if (m_err != {ERR_W{1'b1}}) m_err = m_err + 1'b1;
                        m_state = S_FLT;
                    end
                end
                default: begin
`ifndef TOGGLE_CHK_STICKY_FAULT_EN
                    m_state = S_ACQ;
                    m_good  = '0;
`endif
                end
            endcase
        end
    endtask

    function automatic logic [OUT_W-1:0] model_vec();
        return {m_state, m_state == S_LOCK, m_state == S_FLT, m_tog, m_err};
    endfunction

    task automatic sb_pop();
        logic [OUT_W-1:0] e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_empty at %0t", $time);
        end else begin
            e = exp_q.pop_front();
            check("outputs{state,locked,fault,tog,err}",
                  32'({state, locked, fault, tog_cnt, err_cnt}), 32'(e));
        end
    endtask

    // Called just after a rising edge: drive, predict, wait one edge, compare.
    task automatic step(input logic en_v, input logic do_tog);
        en = en_v;
        if (do_tog) tog_in = ~tog_in;
        model_edge(en_v, tog_in);
        exp_q.push_back(model_vec());
        @(posedge CLK);
        #1;
        sb_pop();
    endtask

    // Drive good toggles (leaving FAULT/IDLE via en as needed) until locked.
    task automatic lock_up();
        for (int i = 0; i < 24; i++) begin
            if (m_state == S_LOCK) break;
            if (m_state == S_FLT) step(1'b0, 1'b1);
            else step(1'b1, 1'b1);
        end
        check("lock_up_locked", 32'(locked), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_state"},   32'(state),   32'd0);
        check({tag, "_locked"},  32'(locked),  32'd0);
        check({tag, "_fault"},   32'(fault),   32'd0);
        check({tag, "_tog_cnt"}, 32'(tog_cnt), 32'd0);
        check({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
    endtask

    initial begin
        logic [CNT_W-1:0] t0;
        logic [ERR_W-1:0] e0;

        // Vectors: {en, toggle this cycle, state after the edge}.
        tbl[0] = '{1'b1, 1'b0, S_ACQ};   // enabling edge, sample ignored
        tbl[1] = '{1'b1, 1'b1, S_ACQ};
        tbl[2] = '{1'b1, 1'b1, S_ACQ};
        tbl[3] = '{1'b1, 1'b1, S_ACQ};
        tbl[4] = '{1'b1, 1'b1, S_LOCK};  // 4th good toggle locks
        tbl[5] = '{1'b1, 1'b1, S_LOCK};
        tbl[6] = '{1'b1, 1'b1, S_LOCK};
        tbl[7] = '{1'b1, 1'b0, S_FLT};   // held level: miss while locked
`ifdef TOGGLE_CHK_STICKY_FAULT_EN
        tbl[8] = '{1'b1, 1'b1, S_FLT};
`else
        tbl[8] = '{1'b1, 1'b1, S_ACQ};
`endif

        RST    = 1'b1;
        en     = 1'b1;
        tog_in = 1'b0;
        model_reset();

        #12;
        check_all_zero("in_reset");
        #8;
        RST = 1'b0;

        // Lock, count, miss.
        for (int i = 0; i < 9; i++) begin
            step(tbl[i].en, tbl[i].tog);
            check($sformatf("tbl%0d_state", i), 32'(state), 32'(tbl[i].exp_state));
        end
        check("tbl_err_cnt", 32'(err_cnt), 32'd1);
        check("tbl_tog_cnt", 32'(tog_cnt), 32'd2);

        // Further misses right after a fault.
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
`ifdef TOGGLE_CHK_STICKY_FAULT_EN
        check("sticky_fault", 32'(fault), 32'd1);
        check("sticky_err", 32'(err_cnt), 32'd1);
        step(1'b0, 1'b1);
        check("sticky_en0_idle", 32'(state), 32'(S_IDLE));
`endif

        // Misses during ACQUIRE reset the acquire count without errors.
        step(1'b0, 1'b1);
        e0 = m_err;
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        check("acq_miss_state", 32'(state), 32'(S_ACQ));
        check("acq_miss_err", 32'(err_cnt), 32'(e0));
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        check("acq_no_early_lock", 32'(locked), 32'd0);
        step(1'b1, 1'b1);
        check("acq_relock", 32'(locked), 32'd1);

        // Good-toggle counter wraps.
        lock_up();
        t0 = m_tog;
        for (int i = 0; i < 17; i++) step(1'b1, 1'b1);
        check("tog_wrap", 32'(tog_cnt), 32'(CNT_W'(t0 + 5'd17)));

        // Error counter saturates.
        for (int i = 0; i < 5; i++) begin
            lock_up();
            step(1'b1, 1'b0);
        end
        check("err_saturate", 32'(err_cnt), 32'd3);

        // Asynchronous reset mid-LOCKED, between edges.
        lock_up();
        #3;
        RST = 1'b1;
        #1;
        check_all_zero("async_reset");
        model_reset();
        @(posedge CLK);
        #1;
        check_all_zero("reset_held");
        RST = 1'b0;
        step(1'b1, 1'b1);
        check("post_reset_acq", 32'(state), 32'(S_ACQ));

        // Randomised tail.
        for (int i = 0; i < 80; i++) begin
            step(($urandom_range(0, 9) != 0), ($urandom_range(0, 5) != 0));
        end

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/toggle_pattern_checker.md
TOGGLE_PATTERN_CHECKER -- requirements
Module: toggle_pattern_checker

Interface
REQ-001 Parameter LOCK_COUNT, default 4: number of consecutive good toggles required to lock; legal range 1..15.
REQ-002 Parameter CNT_W, default 16: width of the good-toggle counter.
REQ-003 Parameter ERR_W, default 8: width of the error counter.
REQ-004 CLK  input  1  clock; the upstream toggle source updates on posedge CLK.
REQ-005 RST  input  1  reset; asynchronous, active-high.
REQ-006 en  input  1  checker enable, sampled on posedge CLK.
REQ-007 tog_in  input  1  upstream toggle signal, expected to invert on every posedge CLK.
REQ-008 state  output  2  current FSM state encoding.
REQ-009 locked  output  1  high while in LOCKED.
REQ-010 fault  output  1  high while in FAULT.
REQ-011 tog_cnt  output  CNT_W  good toggles counted while LOCKED.
REQ-012 err_cnt  output  ERR_W  missed toggles detected while LOCKED.

Function
REQ-013 neg_q SHALL capture tog_in on every negedge CLK (half-cycle retiming).
REQ-014 neg_prev SHALL capture neg_q on every posedge CLK.
REQ-015 At a posedge, ok = (neg_q != neg_prev), evaluated with the pre-edge values.
REQ-016 States: IDLE=0, ACQUIRE=1, LOCKED=2, FAULT=3.
REQ-017 In any state, en=0 at a posedge SHALL give IDLE on the next state; counters hold.
REQ-018 IDLE with en=1 SHALL go to ACQUIRE and clear good_cnt; ok is ignored on that edge.
REQ-019 ACQUIRE with ok SHALL increment good_cnt; when good_cnt == LOCK_COUNT-1 and ok, the next state SHALL be LOCKED.
REQ-020 ACQUIRE with !ok SHALL clear good_cnt, stay in ACQUIRE, and leave err_cnt unchanged.
REQ-021 LOCKED with ok SHALL increment tog_cnt, wrapping from 2^CNT_W-1 to 0.
REQ-022 LOCKED with !ok SHALL increment err_cnt, saturating at 2^ERR_W-1, and go to FAULT; tog_cnt holds.
REQ-023 FAULT behaviour SHALL follow REQ-030/031.
REQ-024 locked and fault SHALL be registered decodes of state, with no extra latency beyond the state register.
REQ-025 Lock latency: LOCK_COUNT good posedges after the edge that enters ACQUIRE.

Reset
REQ-026 RST high SHALL immediately force: state=IDLE, good_cnt=0, tog_cnt=0, err_cnt=0, neg_q=0, neg_prev=0, locked=0, fault=0.
REQ-027 RST asserted mid-operation in any state SHALL take effect without waiting for a clock edge.
REQ-028 Release of RST SHALL be treated as synchronous to CLK by the environment; the first active posedge is the first one after deassertion.

Configuration
REQ-029 Macro TOGGLE_CHK_STICKY_FAULT_EN selects FAULT-exit behaviour.
REQ-030 Defined: FAULT SHALL persist until RST or en=0; misses in FAULT SHALL NOT increment err_cnt.
REQ-031 Undefined: FAULT SHALL last exactly one cycle, then go to ACQUIRE with good_cnt=0.

Structure
REQ-032 Package toggle_chk_pkg SHALL hold the state typedef, the 2-bit encodings, and LOCK_COUNT bounds constants.
REQ-033 The negedge capture flop (REQ-013) SHALL be the sub-module negedge_capture, with async active-high reset.

Verification
REQ-034 Scenario 1: RST=1 for 0–20 ns, 10 ns CLK, en=1, tog_in toggling each posedge -> state=ACQUIRE after the first posedge, then locked=1 after 4 further posedges; tog_cnt increments 1 per cycle.
REQ-035 Scenario 2: while locked, hold tog_in for one extra cycle -> err_cnt=1 and fault=1 on the next cycle; without the macro, ACQUIRE follows, then relock after 4 good toggles.
REQ-036 Scenario 3: TOGGLE_CHK_STICKY_FAULT_EN defined, same stimulus as Scenario 2 -> fault stays 1 and err_cnt stays 1 despite further misses; en=0 -> IDLE.
REQ-037 Scenario 4: assert RST mid-LOCKED, between clock edges -> all outputs 0 immediately, before the next edge.
REQ-038 Scenario 5: CNT_W=4, locked for 17 good toggles -> tog_cnt wraps 15->0 and reads 1; ERR_W=2 with 5 fault cycles -> err_cnt saturates at 3.
REQ-039 Scenario 6: misses during ACQUIRE -> good_cnt clears, err_cnt remains 0, and no lock occurs until 4 consecutive good toggles.
